// File: rtl/uart_tx_word_packer.sv
// Word-to-byte feeder for the UART transmitter: buffers bus words in a small FIFO
// and hands them to the UART one character at a time over data_en/tx_busy.
module uart_tx_word_packer #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          LSB_FIRST  = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WORD_WIDTH-1:0]         s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [BYTE_WIDTH-1:0]         uart_data,
   output logic                          uart_data_en,
   input  logic                          uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          idle
);

   localparam int unsigned NB = WORD_WIDTH / BYTE_WIDTH;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_HI,
      ST_WAIT_LO
   } state_t;

   state_t                state, state_next;
   logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [WORD_WIDTH-1:0] word_r;
   logic [IW-1:0]         idx;
   logic                  wr_en, pop, last_byte;
   logic [CW-1:0]         count_next;

   function automatic logic [BYTE_WIDTH-1:0] pick(input logic [WORD_WIDTH-1:0] w,
                                                 input logic [IW-1:0] i);
      int unsigned k;
      k = 32'(i);
      if (!LSB_FIRST) k = NB - 1 - k;
      return w[k*BYTE_WIDTH +: BYTE_WIDTH];
   endfunction

   assign wr_en      = s_valid & s_ready;
   assign pop        = (state == ST_LOAD);
   assign count_next = fifo_count + CW'(wr_en) - CW'(pop);
   assign last_byte  = (idx == IW'(NB - 1));

   // data_en is combinational so the pulse lands in the same cycle busy is seen low
   assign uart_data_en = (state == ST_SEND) & ~uart_tx_busy & ~rst;
   assign idle         = (fifo_count == '0) & (state == ST_IDLE) & ~uart_tx_busy;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (fifo_count != '0) state_next = ST_LOAD;
         ST_LOAD:    state_next = ST_SEND;
         ST_SEND:    if (!uart_tx_busy) state_next = ST_WAIT_HI;
         ST_WAIT_HI: if (uart_tx_busy) state_next = ST_WAIT_LO;
         ST_WAIT_LO: begin
            if (!uart_tx_busy) begin
               if (!last_byte)             state_next = ST_SEND;
               else if (fifo_count != '0)  state_next = ST_LOAD;
               else                        state_next = ST_IDLE;
            end
         end
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         s_ready    <= 1'b1;
         idx        <= '0;
         word_r     <= '0;
         uart_data  <= '0;
      end else begin
         state      <= state_next;
         fifo_count <= count_next;
         s_ready    <= (count_next != CW'(FIFO_DEPTH));
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         // uart_data only moves on entry to SEND, so it is stable from data_en to busy falling
         case (state)
            ST_LOAD: begin
               word_r    <= mem[rd_ptr];
               idx       <= '0;
               uart_data <= pick(mem[rd_ptr], '0);
            end
            ST_WAIT_LO: begin
               if (!uart_tx_busy && !last_byte) begin
                  idx       <= idx + IW'(1);
                  uart_data <= pick(word_r, idx + IW'(1));
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_word_packer.sv
// Scoreboard bench for uart_tx_word_packer: LSB-first and MSB-first instances,
// each driven by a UART busy model; a monitor checks every data_en byte in order.
module tb_uart_tx_word_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] s_data0 = '0, s_data1 = '0;
   logic        s_valid0 = 1'b0, s_valid1 = 1'b0;
   logic        s_ready0, s_ready1;
   logic [7:0]  uart_data0, uart_data1;
   logic        en0, en1;
   logic        busy0, busy1;
   logic [2:0]  count0, count1;
   logic        idle0, idle1;

   logic        force_busy = 1'b0;
   logic        mbusy0 = 1'b0, mbusy1 = 1'b0;
   int          bcnt0 = 0, bcnt1 = 0;

   assign busy0 = mbusy0 | force_busy;
   assign busy1 = mbusy1;

   uart_tx_word_packer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst(rst), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
      .uart_data(uart_data0), .uart_data_en(en0), .uart_tx_busy(busy0),
      .fifo_count(count0), .idle(idle0));

   uart_tx_word_packer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst(rst), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
      .uart_data(uart_data1), .uart_data_en(en1), .uart_tx_busy(busy1),
      .fifo_count(count1), .idle(idle1));

   // UART model: busy rises the cycle after data_en and stays high for 10 cycles
   always @(posedge clk) begin
      if (en0) begin
         mbusy0 <= 1'b1;
         bcnt0  <= 10;
      end else if (bcnt0 > 0) begin
         bcnt0 <= bcnt0 - 1;
         if (bcnt0 == 1) mbusy0 <= 1'b0;
      end
      if (en1) begin
         mbusy1 <= 1'b1;
         bcnt1  <= 10;
      end else if (bcnt1 > 0) begin
         bcnt1 <= bcnt1 - 1;
         if (bcnt1 == 1) mbusy1 <= 1'b0;
      end
   end

   logic [7:0]  exp_q0[$];
   logic [7:0]  exp_q1[$];
   int          errors = 0;
   int          checks = 0;
   int          pulses0 = 0, pulses1 = 0;
   logic        prev_en0 = 1'b0, prev_en1 = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic mon_byte(input string name, input logic [7:0] data, input logic pen,
                           input logic busy, inout logic [7:0] q[$]);
      logic [7:0] e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected data_en with data %h, expected none", name, data);
      end else begin
         e = q.pop_front();
         // word = {data, previous-cycle data_en, busy}; the pulse must be isolated and busy low
         check(name, 32'({data, pen, busy}), 32'({e, 2'b00}));
      end
   endtask

   function automatic void exp_word0(input logic [31:0] w);
      for (int k = 0; k < 4; k++) exp_q0.push_back(w[k*8 +: 8]);
   endfunction

   task automatic push0(input logic [31:0] w);
      int n = 0;
      s_data0  = w;
      s_valid0 = 1'b1;
      while (!s_ready0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready0) begin
         checks++;
         errors++;
         $display("FAIL push0_timeout: s_ready0 %b after %0d cycles, expected 1", s_ready0, n);
      end
      @(negedge clk);
      s_valid0 = 1'b0;
   endtask

   task automatic push1(input logic [31:0] w);
      int n = 0;
      s_data1  = w;
      s_valid1 = 1'b1;
      while (!s_ready1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready1) begin
         checks++;
         errors++;
         $display("FAIL push1_timeout: s_ready1 %b after %0d cycles, expected 1", s_ready1, n);
      end
      @(negedge clk);
      s_valid1 = 1'b0;
   endtask

   task automatic release_busy();
      @(posedge clk);
      #1 force_busy = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!(idle0 && idle1 && exp_q0.size() == 0 && exp_q1.size() == 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, 32'({idle0, idle1}), 32'b11);
      check({name, "_left"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int          lat;
      int          base;
      int          n;
      logic [31:0] w3 [6];
      logic [2:0]  cnt3 [5];

      w3   = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h0F1E2D3C, 32'h4B5A6978};
      cnt3 = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};

      fork
         forever begin
            @(negedge clk);
            if (en0) begin
               pulses0++;
               mon_byte("dut0_byte", uart_data0, prev_en0, busy0, exp_q0);
            end
            if (en1) begin
               pulses1++;
               mon_byte("dut1_byte", uart_data1, prev_en1, busy1, exp_q1);
            end
            prev_en0 = en0;
            prev_en1 = en1;
         end
      join_none

      // reset values
      repeat (3) @(negedge clk);
      check("rst_s_ready",    32'(s_ready0),   32'd1);
      check("rst_uart_data",  32'(uart_data0), 32'd0);
      check("rst_data_en",    32'(en0),        32'd0);
      check("rst_fifo_count", 32'(count0),     32'd0);
      check("rst_idle",       32'(idle0),      32'd1);
      rst = 1'b0;
      @(negedge clk);

      // single word, both byte orders, first-byte latency
      exp_q0.push_back(8'hD4); exp_q0.push_back(8'hC3);
      exp_q0.push_back(8'hB2); exp_q0.push_back(8'hA1);
      exp_q1.push_back(8'hA1); exp_q1.push_back(8'hB2);
      exp_q1.push_back(8'hC3); exp_q1.push_back(8'hD4);
      fork
         push0(32'hA1B2C3D4);
         push1(32'hA1B2C3D4);
      join
      lat = 1;
      while (!en0 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("first_en_latency", 32'(lat), 32'd3);
      wait_done("single_word");

      // back-to-back fill with UART stalled: write+pop same cycle, full, held source
      force_busy = 1'b1;
      for (int i = 0; i < 6; i++) exp_word0(w3[i]);
      for (int i = 0; i < 5; i++) begin
         push0(w3[i]);
         check($sformatf("fill_count_%0d", i), 32'(count0), 32'(cnt3[i]));
      end
      check("full_s_ready", 32'(s_ready0), 32'd0);
      fork
         push0(w3[5]);
         begin
            repeat (20) @(negedge clk);
            check("held_while_full_count", 32'(count0), 32'd4);
            check("held_while_full_ready", 32'(s_ready0), 32'd0);
            release_busy();
         end
      join
      wait_done("back_to_back");

      // busy held high with a word queued
      force_busy = 1'b1;
      exp_word0(32'hCAFEF00D);
      push0(32'hCAFEF00D);
      base = pulses0;
      repeat (50) @(negedge clk);
      check("busy_hold_no_en", 32'(pulses0 - base), 32'd0);
      release_busy();
      repeat (6) @(negedge clk);
      check("busy_release_one_en", 32'(pulses0 - base), 32'd1);
      wait_done("busy_hold");

      // reset during the second byte with two words queued
      exp_word0(32'h01234567);
      exp_word0(32'h89ABCDEF);
      exp_word0(32'h13579BDF);
      base = pulses0;
      push0(32'h01234567);
      push0(32'h89ABCDEF);
      push0(32'h13579BDF);
      n = 0;
      while (pulses0 - base < 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("second_byte_seen", 32'(pulses0 - base), 32'd2);
      check("queued_before_rst", 32'(count0), 32'd2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q0.delete();
      @(negedge clk);
      check("mid_rst_fifo_count", 32'(count0), 32'd0);
      check("mid_rst_s_ready", 32'(s_ready0), 32'd1);
      rst = 1'b0;
      base = pulses0;
      repeat (30) @(negedge clk);
      check("after_rst_no_en", 32'(pulses0 - base), 32'd0);
      exp_word0(32'hFEEDBEEF);
      push0(32'hFEEDBEEF);
      wait_done("after_rst");
      check("after_rst_pulses", 32'(pulses0 - base), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
